// File: rtl/bus_drive_sequencer_if.sv
// rtl/bus_drive_sequencer_if.sv - request/data inputs and drive/grant outputs of the bus drive sequencer
interface bus_drive_sequencer_if #(
  parameter int SOURCES = 4,
  parameter int WIDTH   = 8
);
  logic [SOURCES-1:0]       Req;
  logic [SOURCES*WIDTH-1:0] Data_in;
  logic [SOURCES-1:0]       Grant;
  logic [SOURCES-1:0]       Ack;
  logic [WIDTH-1:0]         Drive_en;
  logic [WIDTH-1:0]         Drive_data;
  logic                     Busy;

  modport master (
    output Req, Data_in,
    input  Grant, Ack, Drive_en, Drive_data, Busy
  );

  modport slave (
    input  Req, Data_in,
    output Grant, Ack, Drive_en, Drive_data, Busy
  );
endinterface

// File: rtl/bus_drive_sequencer.sv
// rtl/bus_drive_sequencer.sv - round-robin arbiter that drives one shared tristate bus
// through a buffer chain with break-before-make enable sequencing.
module bus_drive_sequencer #(
  parameter int SOURCES     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int DEAD_CYCLES = 1,
  parameter int DELAY_RISE  = 0,
  parameter int DELAY_FALL  = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  bus_drive_sequencer_if.slave bus
);
  localparam int PW   = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int MAXC = (HOLD_CYCLES > DEAD_CYCLES) ? HOLD_CYCLES : DEAD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  if (SOURCES < 2 || SOURCES > 8) begin : g_bad_sources
    $error("bus_drive_sequencer: SOURCES must be 2..8");
  end
  if (HOLD_CYCLES < 1 || DEAD_CYCLES < 1) begin : g_bad_cycles
    $error("bus_drive_sequencer: HOLD_CYCLES and DEAD_CYCLES must be >= 1");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("bus_drive_sequencer: output delays must be non-negative");
  end

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [SOURCES-1:0] r_grant;
  logic [SOURCES-1:0] r_ack;
  logic               r_drive_en;
  logic [WIDTH-1:0]   r_data;

  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_next_ptr;
  logic               w_found;
  logic [SOURCES-1:0] w_onehot;
  logic [WIDTH-1:0]   w_word;

  // Scan requesters starting at the pointer, wrapping past the last source.
  always_comb begin
    logic [PW:0] v_idx;
    v_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < SOURCES; k++) begin
      v_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (v_idx >= (PW+1)'(SOURCES)) begin
        v_idx = v_idx - (PW+1)'(SOURCES);
      end
      if (!w_found && bus.Req[v_idx[PW-1:0]]) begin
        w_win   = v_idx[PW-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_next_ptr = (w_win == PW'(SOURCES - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_onehot = '0;
    w_word   = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (w_win == PW'(i)) begin
        w_onehot[i] = 1'b1;
        w_word      = bus.Data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_drive_en <= 1'b0;
      r_data     <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_onehot;
            r_data  <= w_word;
            r_ptr   <= w_next_ptr;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_drive_en <= 1'b1;
          r_cnt      <= CW'(HOLD_CYCLES - 1);
          r_state    <= S_DRIVE;
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_drive_en <= 1'b0;
            r_ack      <= r_grant;
            r_cnt      <= CW'(DEAD_CYCLES - 1);
            r_state    <= S_TURN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_TURN: begin
          if (r_cnt == '0) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Grant      = r_grant;
  assign bus.Ack        = r_ack;
  assign bus.Busy       = (r_state != S_IDLE);
  assign bus.Drive_en   = {WIDTH{r_drive_en}};
  assign bus.Drive_data = r_data;
endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb/tb_bus_drive_sequencer.sv - scoreboarded bench: transaction-level model pushes expected
// transfers, monitors pop and compare; a second instance runs HOLD=1/DEAD=3 under invariants.
module tb_bus_drive_sequencer;
  localparam int S  = 4;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int D  = 1;
  localparam int H2 = 1;
  localparam int D2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   last_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  bus_drive_sequencer_if #(.SOURCES(S), .WIDTH(W)) bus ();
  bus_drive_sequencer_if #(.SOURCES(S), .WIDTH(W)) bus2 ();

  bus_drive_sequencer #(
    .SOURCES(S), .WIDTH(W), .HOLD_CYCLES(H), .DEAD_CYCLES(D), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  bus_drive_sequencer #(
    .SOURCES(S), .WIDTH(W), .HOLD_CYCLES(H2), .DEAD_CYCLES(D2), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut2 (
    .Clk(clk), .Reset(rst), .bus(bus2)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    last_rst = rst;
  end

  typedef struct {
    int           src;
    logic [W-1:0] word;
    int           g;
  } item_t;
  item_t q[$];

  // Reference model: grant decision per edge from round-robin rule and fixed transfer length.
  int ptr = 0;
  int free_at = 0;
  always @(negedge clk) begin : model
    int    e;
    bit    found;
    item_t it;
    if (last_rst) begin
      q.delete();
      ptr = 0;
      free_at = cyc + 1;
    end
    e = cyc + 1;
    found = 1'b0;
    it.src = 0;
    if (!rst && e >= free_at && bus.Req != '0) begin
      for (int k = 0; k < S; k++) begin
        if (!found && bus.Req[(ptr + k) % S]) begin
          it.src = (ptr + k) % S;
          found = 1'b1;
        end
      end
      it.word = bus.Data_in[it.src*W +: W];
      it.g = e;
      q.push_back(it);
      ptr = (it.src + 1) % S;
      free_at = e + 2 + H + D;
    end
  end

  int           phase = 0;
  int           hi_cnt = 0;
  int           fall_cyc = 0;
  item_t        cur;
  bit           prev_de = 1'b0;
  logic [W-1:0] prev_dd = '0;
  always @(negedge clk) begin : monitor
    bit de;
    if (cyc > 0) begin
      if (last_rst) begin
        check("reset_grant", bus.Grant, 0);
        check("reset_ack", bus.Ack, 0);
        check("reset_drive_en", bus.Drive_en, 0);
        check("reset_drive_data", bus.Drive_data, 0);
        check("reset_busy", bus.Busy, 0);
        phase = 0;
        hi_cnt = 0;
        prev_de = 1'b0;
        prev_dd = bus.Drive_data;
      end else begin
        de = (bus.Drive_en != '0);
        check("grant_onehot0", $onehot0(bus.Grant), 1);
        check("ack_onehot0", $onehot0(bus.Ack), 1);
        check("en_uniform", (bus.Drive_en == '0) || (bus.Drive_en == '1), 1);
        if (bus.Drive_data !== prev_dd) check("en_on_data_change", de, 0);
        if (de && !prev_de) begin
          check("drive_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            phase = 1;
            hi_cnt = 1;
            check("rise_edge", cyc, cur.g + 1);
            check("grant", bus.Grant, 1 << cur.src);
            check("data", bus.Drive_data, cur.word);
            check("busy_drive", bus.Busy, 1);
          end
        end else if (de && phase == 1) begin
          hi_cnt++;
          check("data_hold", bus.Drive_data, cur.word);
          check("grant_hold", bus.Grant, 1 << cur.src);
        end else if (!de && prev_de && phase == 1) begin
          check("hold_len", hi_cnt, H);
          check("ack", bus.Ack, 1 << cur.src);
          check("grant_turn", bus.Grant, 1 << cur.src);
          check("busy_turn", bus.Busy, 1);
          fall_cyc = cyc;
          phase = 2;
        end else if (phase == 2) begin
          if (cyc == fall_cyc + 1) check("ack_pulse", bus.Ack, 0);
          if (cyc == fall_cyc + D) begin
            check("busy_idle", bus.Busy, 0);
            check("grant_release", bus.Grant, 0);
            phase = 0;
          end
        end
        prev_de = de;
        prev_dd = bus.Drive_data;
      end
    end
  end

  int           hi2 = 0;
  int           lo2 = 0;
  bit           seen_fall2 = 1'b0;
  bit           prev_de2 = 1'b0;
  logic [W-1:0] prev_dd2 = '0;
  always @(negedge clk) begin : monitor2
    bit de2;
    if (cyc > 0) begin
      if (last_rst) begin
        hi2 = 0;
        lo2 = 0;
        seen_fall2 = 1'b0;
        prev_de2 = 1'b0;
        prev_dd2 = bus2.Drive_data;
      end else begin
        de2 = (bus2.Drive_en != '0);
        check("p_grant_onehot0", $onehot0(bus2.Grant), 1);
        check("p_ack_onehot0", $onehot0(bus2.Ack), 1);
        if (de2) check("p_en_needs_grant", bus2.Grant != '0, 1);
        if (bus2.Drive_data !== prev_dd2) check("p_en_on_data_change", de2, 0);
        if (de2 && !prev_de2) begin
          if (seen_fall2) check("p_dead_gap", lo2 >= D2 + 2, 1);
          hi2 = 1;
        end else if (de2) begin
          hi2++;
        end
        if (!de2 && prev_de2) begin
          check("p_hold_len", hi2, H2);
          seen_fall2 = 1'b1;
          lo2 = 1;
        end else if (!de2) begin
          lo2++;
        end
        prev_de2 = de2;
        prev_dd2 = bus2.Drive_data;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_word(int i, logic [W-1:0] w);
    bus.Data_in[i*W +: W] = w;
  endtask

  initial begin
    bus2.Req = '0;
    bus2.Data_in = '0;
    while (!done) begin
      @(posedge clk);
      #1;
      bus2.Req = S'($urandom_range(0, 15));
      bus2.Data_in = $urandom;
    end
  end

  initial begin
    rst = 1'b1;
    bus.Req = '0;
    bus.Data_in = '0;
    step(3);
    rst = 1'b0;
    step(1);

    set_word(1, 8'hA5);
    bus.Req = 4'b0010;
    step(1);
    bus.Req = '0;
    step(8);

    set_word(0, 8'h11);
    set_word(1, 8'h22);
    set_word(2, 8'h33);
    set_word(3, 8'h44);
    bus.Req = 4'b1111;
    step(25);
    bus.Req = '0;
    step(8);

    bus.Req = 4'b1000;
    step(1);
    bus.Req = '0;
    step(8);
    bus.Req = 4'b1001;
    step(1);
    bus.Req = '0;
    step(8);

    set_word(2, 8'h77);
    bus.Req = 4'b0100;
    step(1);
    bus.Req = '0;
    step(1);
    bus.Data_in = '0;
    step(8);

    bus.Data_in = 32'h44332211;
    bus.Req = 4'b1111;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(12);
    bus.Req = '0;
    step(8);

    for (int i = 0; i < 400; i++) begin
      bus.Req = ($urandom_range(0, 9) < 3) ? '0 : S'($urandom_range(1, 15));
      bus.Data_in = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    bus.Req = '0;
    step(15);
    check("drain", q.size(), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
